axis_pattern_gen: RTL and testbench

AXI4-Stream test-pattern source that feeds the S2MM (stream-to-memory) channel of the AXI DMA inside the Zynq block design. On a start pulse it emits a programmed number of packets, each of a programmed length, carrying a 32-bit incrementing counter. The DMA writes this data into DDR3, and software checks it over the UART console. Control inputs come from an AXI GPIO in the PL fabric; the stream output connects directly to the DMA S_AXIS_S2MM port.

---
 rtl/axi_dma_pkg.sv | 30 +++
 rtl/axis_pattern_gen.sv | 175 +++++++++++++++++
 tb/tb_axis_pattern_gen.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dma_pkg.sv
// ============================================================================
// Module : axi_dma_pkg
// Brief  : Shared encodings and defaults for the DMA-side stream blocks.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_dma_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 16;
  localparam int DEF_CNT_W  = 16;

  localparam logic [DEF_DATA_W/8-1:0] TKEEP_ALL = '1;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_SEND_ENC = 2'd1;
  localparam logic [1:0] ST_GAP_ENC  = 2'd2;
  localparam logic [1:0] ST_DONE_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_SEND = ST_SEND_ENC,
    ST_GAP  = ST_GAP_ENC,
    ST_DONE = ST_DONE_ENC
  } pg_state_t;

endpackage

`default_nettype wire

// File: rtl/axis_pattern_gen.sv
// ============================================================================
// Module : axis_pattern_gen
// Brief  : AXI4-Stream incrementing-counter packet source for DMA S2MM tests.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_pattern_gen
  import axi_dma_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GAP_CYCLES = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [LEN_W-1:0]    i_pkt_len,
  input  logic [CNT_W-1:0]    i_pkt_num,
  input  logic [DATA_W-1:0]   i_seed,
  output logic                o_busy,
  output logic                o_done,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready
);

  localparam int KEEP_W = DATA_W / 8;

  pg_state_t          r_state;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_num;
  logic [LEN_W-1:0]   r_beat_cnt;
  logic [CNT_W-1:0]   r_pkt_cnt;
  logic [DATA_W-1:0]  r_data;
  logic [KEEP_W-1:0]  r_keep;
  logic               r_valid;
  logic               r_last;
  logic               r_busy;
  logic               r_done;

  logic [LEN_W-1:0]   w_len_m1;
  logic [CNT_W-1:0]   w_num_m1;
  logic               w_single;
  logic               w_gap_done;

  assign w_len_m1 = r_len - LEN_W'(1);
  assign w_num_m1 = r_num - CNT_W'(1);
  assign w_single = (w_len_m1 == '0);

  generate
    if (GAP_CYCLES > 0) begin : g_gap
      localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
      logic [GAP_W-1:0] r_gap_cnt;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_gap_cnt <= '0;
        end else if (r_state == ST_GAP) begin
          r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end else begin
          r_gap_cnt <= '0;
        end
      end

      assign w_gap_done = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
    end else begin : g_no_gap
      assign w_gap_done = 1'b1;
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_num      <= '0;
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
      r_data     <= '0;
      r_keep     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if ((i_pkt_len != '0) && (i_pkt_num != '0)) begin
              r_len      <= i_pkt_len;
              r_num      <= i_pkt_num;
              r_data     <= i_seed;
              r_beat_cnt <= '0;
              r_pkt_cnt  <= '0;
              r_state    <= ST_SEND;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end

        ST_SEND: begin
          // Entry from IDLE spends one cycle with tvalid low before the first beat.
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_keep  <= '1;
            r_busy  <= 1'b1;
            r_last  <= w_single;
          end else if (m_axis_tready) begin
            r_data <= r_data + DATA_W'(1);
            if (r_last) begin
              r_beat_cnt <= '0;
              if (r_pkt_cnt == w_num_m1) begin
                r_valid <= 1'b0;
                r_keep  <= '0;
                r_last  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
                if (GAP_CYCLES > 0) begin
                  r_valid <= 1'b0;
                  r_keep  <= '0;
                  r_last  <= 1'b0;
                  r_state <= ST_GAP;
                end else begin
                  r_last <= w_single;
                end
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + LEN_W'(1);
              r_last     <= ((r_beat_cnt + LEN_W'(1)) == w_len_m1);
            end
          end
        end

        ST_GAP: begin
          if (w_gap_done) begin
            r_valid <= 1'b1;
            r_keep  <= '1;
            r_last  <= w_single;
            r_state <= ST_SEND;
          end
        end

        ST_DONE: begin
          // Zero-length runs arrive with r_done low and raise busy/done here.
          if (!r_done) begin
            r_done <= 1'b1;
            r_busy <= 1'b1;
          end else begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign m_axis_tdata  = r_data;
  assign m_axis_tkeep  = r_keep;
  assign m_axis_tvalid = r_valid;
  assign m_axis_tlast  = r_last;

endmodule

`default_nettype wire

// File: tb/tb_axis_pattern_gen.sv
// ============================================================================
// Module : tb_axis_pattern_gen
// Brief  : Directed self-checking bench for axis_pattern_gen.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_pattern_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start_g = 1'b0;
  logic [15:0] pkt_len = '0;
  logic [15:0] pkt_num = '0;
  logic [31:0] seed = '0;
  logic        tready = 1'b1;

  logic        busy, done, tvalid, tlast;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        busy_g, done_g, tvalid_g, tlast_g;
  logic [31:0] tdata_g;
  logic [3:0]  tkeep_g;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axis_pattern_gen #(.DATA_W(32), .LEN_W(16), .CNT_W(16), .GAP_CYCLES(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_pkt_len(pkt_len), .i_pkt_num(pkt_num), .i_seed(seed),
    .o_busy(busy), .o_done(done),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid),
    .m_axis_tlast(tlast), .m_axis_tready(tready)
  );

  axis_pattern_gen #(.DATA_W(32), .LEN_W(16), .CNT_W(16), .GAP_CYCLES(2)) dut_gap (
    .i_clk(clk), .i_rst(rst), .i_start(start_g),
    .i_pkt_len(pkt_len), .i_pkt_num(pkt_num), .i_seed(seed),
    .o_busy(busy_g), .o_done(done_g),
    .m_axis_tdata(tdata_g), .m_axis_tkeep(tkeep_g), .m_axis_tvalid(tvalid_g),
    .m_axis_tlast(tlast_g), .m_axis_tready(1'b1)
  );

  typedef struct {
    logic [15:0] len;
    logic [15:0] num;
    logic [31:0] seed;
    int          exp_beats;
    logic [31:0] exp_last_word;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Contiguous run with tready high; beat i carries seed+i and tlast on i%len==len-1.
  task automatic run_vec(input vec_t v);
    logic [31:0] last_word;
    last_word = '0;
    @(negedge clk);
    pkt_len = v.len; pkt_num = v.num; seed = v.seed; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("latency_valid_low", {31'd0, tvalid}, 32'd0);
    check("latency_busy_low", {31'd0, busy}, 32'd0);
    @(negedge clk);
    if (v.exp_beats == 0) begin
      check("zero_done", {31'd0, done}, 32'd1);
      check("zero_busy", {31'd0, busy}, 32'd1);
      check("zero_valid", {31'd0, tvalid}, 32'd0);
      @(negedge clk);
      check("zero_done_fall", {31'd0, done}, 32'd0);
      check("zero_busy_fall", {31'd0, busy}, 32'd0);
    end else begin
      for (int i = 0; i < v.exp_beats; i++) begin
        check("beat_valid", {31'd0, tvalid}, 32'd1);
        check("beat_data", tdata, v.seed + 32'(i));
        check("beat_last", {31'd0, tlast}, {31'd0, ((i % int'(v.len)) == int'(v.len) - 1)});
        check("beat_busy", {31'd0, busy}, 32'd1);
        if (i == 0) check("beat_keep", {28'd0, tkeep}, 32'hF);
        last_word = tdata;
        @(negedge clk);
      end
      check("final_word", last_word, v.exp_last_word);
      check("end_valid", {31'd0, tvalid}, 32'd0);
      check("end_done", {31'd0, done}, 32'd1);
      check("end_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("done_fall", {31'd0, done}, 32'd0);
      check("busy_fall", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] exp_word;
    logic [31:0] saved_data;
    logic        saved_last;
    logic        stalled;
    logic        done_seen;
    int          hs;
    int          gap;
    int          lasts;
    int          beats;

    vecs[0] = '{16'd4, 16'd1, 32'h0000_0010, 4, 32'h0000_0013};
    vecs[1] = '{16'd3, 16'd3, 32'hFFFF_FFFE, 9, 32'h0000_0006};
    vecs[2] = '{16'd1, 16'd3, 32'h0000_00AB, 3, 32'h0000_00AD};
    vecs[3] = '{16'd0, 16'd5, 32'h0000_0077, 0, 32'h0000_0000};
    vecs[4] = '{16'd4, 16'd0, 32'h0000_0077, 0, 32'h0000_0000};

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_valid", {31'd0, tvalid}, 32'd0);
    check("rst_last", {31'd0, tlast}, 32'd0);
    check("rst_keep", {28'd0, tkeep}, 32'd0);
    check("rst_data", tdata, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // Second start mid-run must neither restart nor re-latch.
    @(negedge clk);
    pkt_len = 16'd4; pkt_num = 16'd1; seed = 32'h200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("ign_data", tdata, 32'h200 + 32'(i));
      check("ign_last", {31'd0, tlast}, {31'd0, (i == 3)});
      if (i == 1) begin start = 1'b1; pkt_len = 16'd7; seed = 32'h999; end
      if (i == 2) start = 1'b0;
      @(negedge clk);
    end
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_valid", {31'd0, tvalid}, 32'd0);
    @(negedge clk);

    // Random backpressure, len=8 num=2.
    @(negedge clk);
    pkt_len = 16'd8; pkt_num = 16'd2; seed = 32'h1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_word = 32'h1000; hs = 0; stalled = 1'b0; done_seen = 1'b0;
    saved_data = '0; saved_last = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (stalled) begin
        check("stall_valid", {31'd0, tvalid}, 32'd1);
        check("stall_data", tdata, saved_data);
        check("stall_last", {31'd0, tlast}, {31'd0, saved_last});
      end
      if (done) begin done_seen = 1'b1; break; end
      tready = 1'($urandom_range(0, 1));
      stalled = 1'b0;
      if (tvalid) begin
        if (tready) begin
          check("rand_data", tdata, exp_word);
          check("rand_last", {31'd0, tlast}, {31'd0, ((hs % 8) == 7)});
          exp_word = exp_word + 32'd1;
          hs++;
        end else begin
          stalled = 1'b1; saved_data = tdata; saved_last = tlast;
        end
      end
      @(negedge clk);
    end
    tready = 1'b1;
    check("rand_done_seen", {31'd0, done_seen}, 32'd1);
    check("rand_handshakes", 32'(hs), 32'd16);
    @(negedge clk);
    check("rand_busy_fall", {31'd0, busy}, 32'd0);

    // Gap variant: exactly two idle cycles between packets.
    @(negedge clk);
    pkt_len = 16'd2; pkt_num = 16'd2; seed = 32'h100; start_g = 1'b1;
    @(negedge clk);
    start_g = 1'b0;
    exp_word = 32'h100; gap = 0; lasts = 0; beats = 0; done_seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (done_g) begin done_seen = 1'b1; break; end
      if (tvalid_g) begin
        check("gap_data", tdata_g, exp_word);
        exp_word = exp_word + 32'd1;
        beats++;
        if (tlast_g) lasts++;
      end else if (lasts == 1) begin
        gap++;
      end
      @(negedge clk);
    end
    check("gap_done_seen", {31'd0, done_seen}, 32'd1);
    check("gap_cycles", 32'(gap), 32'd2);
    check("gap_beats", 32'(beats), 32'd4);
    @(negedge clk);

    // Reset after two of four beats, then a clean restart from seed 0.
    @(negedge clk);
    pkt_len = 16'd4; pkt_num = 16'd1; seed = 32'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_data", tdata, 32'h57);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, tvalid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_data", tdata, 32'd0);
    check("mid_rst_keep", {28'd0, tkeep}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec('{16'd4, 16'd1, 32'h0, 4, 32'h3});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
